// File: rtl/seg_scan_driver_pkg.sv
// Shared types and helpers for the scanned seven-segment driver.
// Optional brightness control is enabled with SEG_SCAN_BRIGHTNESS_EN.
package seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_BLANK = 2'd2
   } scan_st_e;

   localparam logic [31:0] SEG_OFF = '0;

   // Physical level of one anode line given its logical enable.
   function automatic logic an_pol(input logic on, input logic act_low);
      return on ^ act_low;
   endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Pattern input / scanned display output bundle for seg_scan_driver.
// bright_i exists only when SEG_SCAN_BRIGHTNESS_EN is defined.
interface seg_scan_driver_if #(
   parameter int NUM_DIGITS = 4,
   parameter int SEG_W      = 8
);
   localparam int DW = $clog2(NUM_DIGITS);

   logic                        en_i;
   logic                        load_i;
   logic [NUM_DIGITS*SEG_W-1:0] seg_i;
   logic [NUM_DIGITS-1:0]       an_o;
   logic [SEG_W-1:0]            seg_o;
   logic                        frame_o;
   logic [DW-1:0]               digit_o;

`ifdef SEG_SCAN_BRIGHTNESS_EN
   logic [3:0]                  bright_i;

   modport slave  (input  en_i, load_i, seg_i, bright_i,
                   output an_o, seg_o, frame_o, digit_o);
   modport master (output en_i, load_i, seg_i, bright_i,
                   input  an_o, seg_o, frame_o, digit_o);
`else
   modport slave  (input  en_i, load_i, seg_i,
                   output an_o, seg_o, frame_o, digit_o);
   modport master (output en_i, load_i, seg_i,
                   input  an_o, seg_o, frame_o, digit_o);
`endif

endinterface

// File: rtl/seg_scan_driver_slot_timer.sv
// Per-digit slot counter with DRIVE/slot end strobes and a lit window
// compare on the next count (used by SEG_SCAN_BRIGHTNESS_EN dimming).
module seg_slot_timer #(
   parameter int DIV       = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run_i,
   input  logic [31:0] lim_i,
   output logic        drive_end_o,
   output logic        slot_end_o,
   output logic        lit_nxt_o
);
   localparam int CW = $clog2(DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   assign drive_end_o = (cnt_q == CW'(DIV - BLANK_CYC - 1));
   assign slot_end_o  = (cnt_q == CW'(DIV - 1));

   always_comb begin
      cnt_d = '0;
      if (run_i && !slot_end_o) cnt_d = cnt_q + CW'(1);
   end

   // Compared against the next count so the registered anode lands aligned.
   assign lit_nxt_o = (32'(cnt_d) < lim_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed, double-buffered seven-segment scan driver with dead-time.
// Define SEG_SCAN_BRIGHTNESS_EN to add per-frame PWM brightness (bright_i).
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int SEG_W         = 8,
   parameter int DIV           = 50000,
   parameter int BLANK_CYC     = 500,
   parameter int AN_ACTIVE_LOW = 1
) (
   input logic              clk,
   input logic              rst_n,
   seg_scan_driver_if.slave bus_io
);
   localparam int   DW      = $clog2(NUM_DIGITS);
   localparam logic ACT_LOW = (AN_ACTIVE_LOW != 0);

   scan_st_e                         state_q, state_d;
   logic [DW-1:0]                    digit_q, digit_d, digit_nxt;
   logic [NUM_DIGITS-1:0][SEG_W-1:0] active_q, active_d, pend_q, pend_d;
   logic                             pend_vld_q, pend_vld_d;
   logic [NUM_DIGITS-1:0]            an_q, an_d, an_off;
   logic [SEG_W-1:0]                 seg_q, seg_d;
   logic                             frame_q, frame_d;
   logic                             boundary, run, drive_end, slot_end, lit_nxt, lit;
   logic [31:0]                      lim;

   assign run       = (state_q != ST_IDLE) && bus_io.en_i;
   assign digit_nxt = (digit_q == DW'(NUM_DIGITS - 1)) ? '0 : digit_q + DW'(1);

   seg_slot_timer #(
      .DIV       (DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .run_i       (run),
      .lim_i       (lim),
      .drive_end_o (drive_end),
      .slot_end_o  (slot_end),
      .lit_nxt_o   (lit_nxt)
   );

`ifdef SEG_SCAN_BRIGHTNESS_EN
   logic [3:0] bright_q, bright_d;

   // Brightness only changes on a frame boundary so a frame is uniformly lit.
   assign bright_d = boundary ? bus_io.bright_i : bright_q;
   assign lim      = (32'(DIV - BLANK_CYC) * {28'd0, bright_d}) >> 4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bright_q <= '0;
      else        bright_q <= bright_d;
   end
`else
   assign lim = 32'(DIV);
`endif

   always_comb begin
      for (int k = 0; k < NUM_DIGITS; k++) an_off[k] = an_pol(1'b0, ACT_LOW);
   end

   always_comb begin
      state_d  = state_q;
      digit_d  = digit_q;
      boundary = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus_io.en_i) begin
               state_d  = ST_DRIVE;
               digit_d  = '0;
               boundary = 1'b1;
            end
         end
         ST_DRIVE: begin
            if (drive_end) begin
               if (BLANK_CYC == 0) begin
                  digit_d  = digit_nxt;
                  boundary = (digit_nxt == '0);
               end else begin
                  state_d = ST_BLANK;
               end
            end
         end
         ST_BLANK: begin
            if (slot_end) begin
               state_d  = ST_DRIVE;
               digit_d  = digit_nxt;
               boundary = (digit_nxt == '0);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (!bus_io.en_i) begin
         state_d  = ST_IDLE;
         digit_d  = '0;
         boundary = 1'b0;
      end
   end

   // A load coinciding with the boundary bypasses pending and lands directly.
   always_comb begin
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      active_d   = active_q;
      if (bus_io.load_i) begin
         pend_d     = bus_io.seg_i;
         pend_vld_d = 1'b1;
      end
      if (boundary) begin
         if (bus_io.load_i)   active_d = bus_io.seg_i;
         else if (pend_vld_q) active_d = pend_q;
         pend_vld_d = 1'b0;
      end
   end

   always_comb begin
      lit     = (state_d == ST_DRIVE) && lit_nxt;
      frame_d = boundary;
      seg_d   = lit ? active_d[digit_d] : SEG_OFF[SEG_W-1:0];
      for (int k = 0; k < NUM_DIGITS; k++)
         an_d[k] = an_pol(lit && (digit_d == DW'(k)), ACT_LOW);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         digit_q    <= '0;
         active_q   <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         an_q       <= an_off;
         seg_q      <= '0;
         frame_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         digit_q    <= digit_d;
         active_q   <= active_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         frame_q    <= frame_d;
      end
   end

   assign bus_io.an_o    = an_q;
   assign bus_io.seg_o   = seg_q;
   assign bus_io.frame_o = frame_q;
   assign bus_io.digit_o = digit_q;

endmodule
